// File: rtl/ica_pkg.sv
// -----------------------------------------------------------------------------
// ica_pkg
// Shared definitions for the ICA remix datapath:
//   - default geometry and widths (DEF_SIZE_N, DEF_SIZE_C, DEF_DATA_W,
//     DEF_COEF_W, DEF_FRAC_W)
//   - remix_state_t, the frame sequencer states
//   - sat_round(), the fixed-point output stage (shift, optional rounding,
//     saturation)
// Build option: IC_REMIX_ROUND_EN adds half an LSB before the shift
// (round half up). Without it the shift floors.
// -----------------------------------------------------------------------------
package ica_pkg;

  localparam int DEF_SIZE_N = 8;
  localparam int DEF_SIZE_C = 3;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_FRAC_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } remix_state_t;

  // Accumulator arrives sign-extended to 64 bits so a single function
  // serves any parameterisation of the top level.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input int                 data_w,
    input int                 frac_w
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = acc;
`ifdef IC_REMIX_ROUND_EN
    v = v + (64'sd1 <<< (frac_w - 1));
`endif
    v  = v >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/remix_mac.sv
// -----------------------------------------------------------------------------
// remix_mac
// Registered signed multiply-accumulate with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : acc <= 0 on the next edge (wins over en)
//   en         : acc <= acc + a*b on the next edge
//   a, b       : signed operands (DATA_W, COEF_W)
//   acc        : signed accumulator (ACC_W), sized by the parent so it
//                cannot overflow over one output channel
// -----------------------------------------------------------------------------
module remix_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a variable unassigned and no latch appears.
    acc_d = acc_q;
    prod  = PROD_W'(a) * PROD_W'(b);
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ic_remix.sv
// -----------------------------------------------------------------------------
// ic_remix
// Rebuilds SIZE_N sensor channels from SIZE_C independent components,
// x_hat[n] = sum_c W[n][c] * s[c], with a per-component mask. One shared
// MAC spends SIZE_C cycles per channel; channels leave one per handshake.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   coef_we/coef_row/coef_col/coef_data coefficient write (idle only)
//   comp_mask                           bit c = 1 keeps component c
//   in_valid/in_ready/in_data           one packed C-component sample
//   out_valid/out_ready                 channel handshake
//   out_data/out_chan/out_last          channel sample, index, last flag
//   busy                                a frame is in flight
// Build option: IC_REMIX_ROUND_EN selects round-half-up instead of floor.
// -----------------------------------------------------------------------------
module ic_remix
  import ica_pkg::*;
#(
  parameter int SIZE_N = DEF_SIZE_N,
  parameter int SIZE_C = DEF_SIZE_C,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int FRAC_W = DEF_FRAC_W,
  localparam int RW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1,
  localparam int CW = (SIZE_C > 1) ? $clog2(SIZE_C) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [RW-1:0]            coef_row,
  input  logic [CW-1:0]            coef_col,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic [SIZE_C-1:0]        comp_mask,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE_C*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [RW-1:0]            out_chan,
  output logic                     out_last,
  output logic                     busy
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(SIZE_C) + 1;

  remix_state_t             state_d, state_q;
  logic [RW-1:0]            chan_d, chan_q;
  logic [CW-1:0]            comp_d, comp_q;
  logic [SIZE_C-1:0]        mask_d, mask_q;
  logic signed [DATA_W-1:0] samp_d [SIZE_C];
  logic signed [DATA_W-1:0] samp_q [SIZE_C];
  logic signed [COEF_W-1:0] coef_d [SIZE_N][SIZE_C];
  logic signed [COEF_W-1:0] coef_q [SIZE_N][SIZE_C];

  logic                     mac_clear;
  logic                     mac_en;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [COEF_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  acc;

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    comp_d    = comp_q;
    mask_d    = mask_q;
    samp_d    = samp_q;
    coef_d    = coef_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int c = 0; c < SIZE_C; c++) begin
            samp_d[c] = in_data[c*DATA_W +: DATA_W];
          end
          mask_d    = comp_mask;
          chan_d    = '0;
          comp_d    = '0;
          mac_clear = 1'b1;
          state_d   = MAC;
        end
      end
      MAC: begin
        // Masked components still spend their cycle (operand forced to 0)
        // so output latency does not depend on the mask.
        mac_en = 1'b1;
        if (comp_q == CW'(SIZE_C - 1)) begin
          comp_d  = '0;
          state_d = OUT;
        end else begin
          comp_d = comp_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (chan_q == RW'(SIZE_N - 1)) begin
            chan_d  = '0;
            state_d = IDLE;
          end else begin
            chan_d    = chan_q + 1'b1;
            mac_clear = 1'b1;
            state_d   = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Coefficients only change between frames; a write landing on the
    // accept edge is already in place for the frame's first MAC cycle.
    if (coef_we && (state_q == IDLE) &&
        (int'(coef_row) < SIZE_N) && (int'(coef_col) < SIZE_C)) begin
      coef_d[coef_row][coef_col] = coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      comp_q  <= '0;
      mask_q  <= '0;
      for (int c = 0; c < SIZE_C; c++) begin
        samp_q[c] <= '0;
      end
      // NOTE: the coefficient store is a flop array, not a RAM macro, so it
      // can and must be cleared by reset to give a known W after power-up.
      for (int n = 0; n < SIZE_N; n++) begin
        for (int c = 0; c < SIZE_C; c++) begin
          coef_q[n][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      comp_q  <= comp_d;
      mask_q  <= mask_d;
      samp_q  <= samp_d;
      coef_q  <= coef_d;
    end
  end

  assign mac_a = mask_q[comp_q] ? samp_q[comp_q] : '0;
  assign mac_b = coef_q[chan_q][comp_q];

  remix_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc)
  );

  // acc is frozen while in OUT, so the outputs hold until out_ready.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_chan  = chan_q;
  assign out_last  = (state_q == OUT) && (chan_q == RW'(SIZE_N - 1));
  assign out_data  = (state_q == OUT)
                   ? DATA_W'(sat_round({{(64 - ACC_W){acc[ACC_W-1]}}, acc},
                                       DATA_W, FRAC_W))
                   : '0;

endmodule

// File: tb/tb_ic_remix.sv
// -----------------------------------------------------------------------------
// tb_ic_remix
// Directed bench for ic_remix. A frame-level model (coefficient table plus
// integer arithmetic) predicts every channel of every accepted frame; a
// negedge monitor compares outputs, handshake timing and stall stability.
// Literal checks on captured channels pin the model.
// -----------------------------------------------------------------------------
module tb_ic_remix;

  localparam int N = 8;
  localparam int C = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_row = '0;
  logic [1:0]         coef_col = '0;
  logic signed [15:0] coef_data = '0;
  logic [2:0]         comp_mask = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [47:0]        in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic [2:0]         out_chan;
  logic               out_last;
  logic               busy;

  ic_remix dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_we   (coef_we),
    .coef_row  (coef_row),
    .coef_col  (coef_col),
    .coef_data (coef_data),
    .comp_mask (comp_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    longint data;
    int     chan;
    bit     last;
  } exp_t;

  longint mw [N][C];
  exp_t   q [$];
  longint got [N];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  // Channel value straight from the definition: masked dot product, then
  // floor (or round-half-up) division by 2^14 and clamping to 16 bits.
  function automatic longint model_chan(input int n, input logic [47:0] d,
                                        input logic [2:0] m);
    longint sum;
    longint quo;
    sum = 0;
    for (int c = 0; c < C; c++) begin
      if (m[c]) sum += mw[n][c] * longint'($signed(d[c*16 +: 16]));
    end
`ifdef IC_REMIX_ROUND_EN
    sum += 8192;
`endif
    quo = sum / 16384;
    if ((sum % 16384) != 0 && sum < 0) quo -= 1;
    if (quo > 32767) quo = 32767;
    if (quo < -32768) quo = -32768;
    return quo;
  endfunction

  // Monitor: compares every cycle against the model queue.
  bit     wait_first = 0;
  int     cyc = 0;
  bit     prev_hold = 0;
  longint prev_data = 0;
  longint prev_chan = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      wait_first = 0;
      prev_hold  = 0;
    end else begin
      if (wait_first) cyc++;
      check("in_ready", in_ready, q.size() == 0);
      check("busy", busy, q.size() != 0);
      if (q.size() == 0) check("idle_out_valid", out_valid, 0);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_chan", out_chan, prev_chan);
      end
      if (out_valid && q.size() > 0) begin
        if (wait_first) begin
          check("latency", cyc, C + 1);
          wait_first = 0;
        end
        check("data", out_data, q[0].data);
        check("chan", out_chan, q[0].chan);
        check("last", out_last, q[0].last);
        if (out_ready) begin
          got[out_chan] = out_data;
          void'(q.pop_front());
          if (q.size() > 0) begin
            wait_first = 1;
            cyc = 0;
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_chan = out_chan;
      if (in_valid && in_ready) begin
        for (int n = 0; n < N; n++) begin
          q.push_back('{model_chan(n, in_data, comp_mask), n, n == N - 1});
        end
        wait_first = 1;
        cyc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int r, input int c, input longint v, input bit apply);
    coef_we   = 1'b1;
    coef_row  = r[2:0];
    coef_col  = c[1:0];
    coef_data = 16'(v);
    if (apply) mw[r][c] = v;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send_frame(input longint s0, input longint s1, input longint s2,
                            input logic [2:0] m);
    int k;
    in_data   = {16'(s2), 16'(s1), 16'(s0)};
    comp_mask = m;
    in_valid  = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) timeout_fail("accept");
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) timeout_fail("frame_done");
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_chan"}, out_chan, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    for (int n = 0; n < N; n++)
      for (int c = 0; c < C; c++) mw[n][c] = 0;

    // Reset values
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    // 1. Identity W, all components
    for (int n = 0; n < C; n++) write_coef(n, n, 16384, 1);
    send_frame(100, -200, 300, 3'b111);
    wait_idle();
    check("t1_ch0", got[0], 100);
    check("t1_ch1", got[1], -200);
    check("t1_ch2", got[2], 300);
    check("t1_ch5", got[5], 0);

    // 2. Component 1 masked out
    send_frame(100, -200, 300, 3'b101);
    wait_idle();
    check("t2_ch0", got[0], 100);
    check("t2_ch1", got[1], 0);
    check("t2_ch2", got[2], 300);

    // 3. Saturation both ways
    for (int n = 0; n < N; n++)
      for (int c = 0; c < C; c++) write_coef(n, c, 32767, 1);
    send_frame(32767, 32767, 32767, 3'b111);
    wait_idle();
    check("t3_pos_ch0", got[0], 32767);
    check("t3_pos_ch7", got[7], 32767);
    send_frame(-32768, -32768, -32768, 3'b111);
    wait_idle();
    check("t3_neg_ch4", got[4], -32768);

    // 4. Back-pressure: hold out_ready low for 5 cycles with out_valid up
    out_ready = 1'b0;
    send_frame(1, 2, 3, 3'b111);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 50) begin
        tick();
        k++;
      end
      if (k >= 50) timeout_fail("stall_valid");
    end
    repeat (5) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_chan", out_chan, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
`ifdef IC_REMIX_ROUND_EN
    check("t4_ch0", got[0], 12);
    check("t4_ch7", got[7], 12);
`else
    check("t4_ch0", got[0], 11);
    check("t4_ch7", got[7], 11);
`endif

    // 5. Rounding; the write shares the accept edge and applies to the frame
    coef_we   = 1'b1;
    coef_row  = 3'd0;
    coef_col  = 2'd0;
    coef_data = 16'sd8192;
    mw[0][0]  = 8192;
    send_frame(3, 0, 0, 3'b111);
    wait_idle();
`ifdef IC_REMIX_ROUND_EN
    check("t5_pos", got[0], 2);
`else
    check("t5_pos", got[0], 1);
`endif
    send_frame(-3, 0, 0, 3'b111);
    wait_idle();
`ifdef IC_REMIX_ROUND_EN
    check("t5_neg", got[0], -1);
`else
    check("t5_neg", got[0], -2);
`endif

    // 6. Reset mid-frame at channel 3
    out_ready = 1'b0;
    send_frame(1000, 1000, 1000, 3'b111);
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        if (out_valid && out_chan == 3'd3) begin
          found = 1;
        end else if (out_valid) begin
          out_ready = 1'b1;
          tick();
          out_ready = 1'b0;
        end else begin
          tick();
        end
      end
      if (!found) timeout_fail("reach_chan3");
    end
    rst_n = 1'b0;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < C; c++) mw[n][c] = 0;
    tick();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check_reset_outputs("rel");
    send_frame(1000, 1000, 1000, 3'b111);
    wait_idle();
    check("t6_cleared_ch0", got[0], 0);
    check("t6_cleared_ch7", got[7], 0);

    // Write during MAC is dropped; two frames read back the old W[0][0]
    write_coef(0, 0, 16384, 1);
    send_frame(5, 0, 0, 3'b111);
    write_coef(0, 0, -16384, 0);
    wait_idle();
    check("t6_busy_write_a", got[0], 5);
    send_frame(7, 0, 0, 3'b111);
    wait_idle();
    check("t6_busy_write_b", got[0], 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
